// File: rtl/cbfp_denorm.sv
// CBFP denormalizer: restores block-floating-point lane samples to full-width
// fixed point over a two-stage pipeline, tracking frame position and index saturation.
module cbfp_denorm #(
  parameter int I_WIDTH    = 12,
  parameter int O_WIDTH    = 24,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_SHIFT  = 12,
  parameter int BEATS      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic signed [I_WIDTH-1:0] din_re   [DATA_WIDTH],
  input  logic signed [I_WIDTH-1:0] din_im   [DATA_WIDTH],
  input  logic        [4:0]         index_in [DATA_WIDTH],
  output logic signed [O_WIDTH-1:0] dout_re  [DATA_WIDTH],
  output logic signed [O_WIDTH-1:0] dout_im  [DATA_WIDTH],
  output logic                      valid_out,
  output logic                      frame_start,
  output logic                      frame_end,
  output logic                      idx_sat
);

  localparam int            CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [4:0]    MAX_IDX   = 5'(MAX_SHIFT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic                      s1Valid_q;
  logic                      s1Sat_q;
  logic                      s1Sat_d;
  logic signed [I_WIDTH-1:0] s1Re_q   [DATA_WIDTH];
  logic signed [I_WIDTH-1:0] s1Im_q   [DATA_WIDTH];
  logic        [4:0]         s1Idx_q  [DATA_WIDTH];
  logic        [4:0]         s1Idx_d  [DATA_WIDTH];

  logic                      outValid_q;
  logic                      sat_q;
  logic        [CW-1:0]      beat_q;
  logic        [4:0]         shamt    [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] outRe_d  [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] outIm_d  [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] outRe_q  [DATA_WIDTH];
  logic signed [O_WIDTH-1:0] outIm_q  [DATA_WIDTH];

  // Clamp each lane's exponent so the restore shift never goes negative.
  always_comb begin
    s1Sat_d = 1'b0;
    for (int l = 0; l < DATA_WIDTH; l++) begin
      if (index_in[l] > MAX_IDX) begin
        s1Idx_d[l] = MAX_IDX;
        s1Sat_d    = 1'b1;
      end else begin
        s1Idx_d[l] = index_in[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Sat_q   <= 1'b0;
      for (int l = 0; l < DATA_WIDTH; l++) begin
        s1Re_q[l]  <= '0;
        s1Im_q[l]  <= '0;
        s1Idx_q[l] <= '0;
      end
    end else begin
      s1Valid_q <= valid_in;
      if (valid_in) begin
        s1Sat_q <= s1Sat_d;
        s1Re_q  <= din_re;
        s1Im_q  <= din_im;
        s1Idx_q <= s1Idx_d;
      end
    end
  end

  // Output width leaves exactly MAX_SHIFT bits of headroom, so the shift is lossless.
  always_comb begin
    for (int l = 0; l < DATA_WIDTH; l++) begin
      shamt[l]   = MAX_IDX - s1Idx_q[l];
      outRe_d[l] = $signed({{(O_WIDTH-I_WIDTH){s1Re_q[l][I_WIDTH-1]}}, s1Re_q[l]}) <<< shamt[l];
      outIm_d[l] = $signed({{(O_WIDTH-I_WIDTH){s1Im_q[l][I_WIDTH-1]}}, s1Im_q[l]}) <<< shamt[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      sat_q      <= 1'b0;
      beat_q     <= '0;
      for (int l = 0; l < DATA_WIDTH; l++) begin
        outRe_q[l] <= '0;
        outIm_q[l] <= '0;
      end
    end else begin
      outValid_q <= s1Valid_q;
      sat_q      <= sat_q | (s1Valid_q & s1Sat_q);
      if (s1Valid_q) begin
        outRe_q <= outRe_d;
        outIm_q <= outIm_d;
      end
      // beat_q names the beat currently on the outputs; it moves once that beat is consumed.
      if (outValid_q) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : CW'(beat_q + 1'b1);
      end
    end
  end

  assign valid_out   = outValid_q;
  assign frame_start = outValid_q && (beat_q == '0);
  assign frame_end   = outValid_q && (beat_q == LAST_BEAT);
  assign idx_sat     = sat_q;
  assign dout_re     = outRe_q;
  assign dout_im     = outIm_q;

endmodule

// File: tb/tb_cbfp_denorm.sv
// Directed testbench for cbfp_denorm: latency, shift arithmetic, saturation flag,
// frame flags across gaps, back-to-back frames and mid-frame reset.
module tb_cbfp_denorm;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_in;
  logic signed [11:0] din_re   [16];
  logic signed [11:0] din_im   [16];
  logic        [4:0]  index_in [16];
  logic signed [23:0] dout_re  [16];
  logic signed [23:0] dout_im  [16];
  logic               valid_out;
  logic               frame_start;
  logic               frame_end;
  logic               idx_sat;

  int checks   = 0;
  int failures = 0;

  cbfp_denorm dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .din_re     (din_re),
    .din_im     (din_im),
    .index_in   (index_in),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .valid_out  (valid_out),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .idx_sat    (idx_sat)
  );

  always #5 clk = ~clk;

  // Reference restore: multiply by a power of two rather than shifting.
  function automatic logic signed [23:0] refShift(input logic signed [11:0] d, input logic [4:0] idx);
    longint k;
    k = (int'(idx) >= 12) ? 0 : 12 - int'(idx);
    return 24'(longint'(d) * (longint'(1) << k));
  endfunction

  function automatic logic signed [11:0] patRe(input int b, input int l);
    return 12'(((b * 37 + l * 11) % 4096) - 2048);
  endfunction

  function automatic logic signed [11:0] patIm(input int b, input int l);
    return 12'(((b * 53 + l * 29 + 100) % 4096) - 2048);
  endfunction

  function automatic logic [4:0] patIdx(input int b, input int l);
    return 5'((b + 3 * l) % 16);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setBeat(input int b);
    for (int l = 0; l < 16; l++) begin
      din_re[l]   = patRe(b, l);
      din_im[l]   = patIm(b, l);
      index_in[l] = patIdx(b, l);
    end
  endtask

  task automatic setAll(input logic signed [11:0] re, input logic signed [11:0] im, input logic [4:0] idx);
    for (int l = 0; l < 16; l++) begin
      din_re[l]   = re;
      din_im[l]   = im;
      index_in[l] = idx;
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    valid_in = 1'b0;
    setAll(12'sd0, 12'sd0, 5'd0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    valid_in = 1'b1;
    setBeat(3);
    cycle();
    cycle();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b required=0", valid_out); end
    checks++; if (frame_start !== 1'b0 || frame_end !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags actual=%b%b required=00", frame_start, frame_end); end
    checks++; if (idx_sat !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat actual=%b required=0", idx_sat); end
    checks++; if (dout_re[0] !== 24'sd0 || dout_im[15] !== 24'sd0) begin failures++; $display("[TB] FAIL reset_dout actual=%0d/%0d required=0/0", dout_re[0], dout_im[15]); end
    rst = 1'b0;
    cycle();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_valid actual=%b required=0", valid_out); end
    valid_in = 1'b0;
  endtask

  task automatic test_unit_shift();
    doReset();
    setAll(12'sd1, 12'sd0, 5'd0);
    valid_in = 1'b1;
    cycle();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL unit_latency actual=%b required=0", valid_out); end
    valid_in = 1'b0;
    cycle();
    checks++; if (valid_out !== 1'b1 || frame_start !== 1'b1 || frame_end !== 1'b0) begin
      failures++; $display("[TB] FAIL unit_flags actual=%b%b%b required=110", valid_out, frame_start, frame_end);
    end
    for (int l = 0; l < 16; l++) begin
      checks++; if (dout_re[l] !== 24'sd4096) begin failures++; $display("[TB] FAIL unit_re lane=%0d actual=%0d required=4096", l, dout_re[l]); end
    end
    cycle();
    checks++; if (valid_out !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("[TB] FAIL unit_idle actual=%b%b required=00", valid_out, frame_start); end
    checks++; if (dout_re[7] !== 24'sd4096) begin failures++; $display("[TB] FAIL unit_hold actual=%0d required=4096", dout_re[7]); end
  endtask

  task automatic test_mixed_index();
    doReset();
    setAll(12'sd0, -12'sd2048, 5'd12);
    index_in[1] = 5'd5;
    valid_in    = 1'b1;
    cycle();
    valid_in = 1'b0;
    cycle();
    checks++; if (dout_im[0] !== -24'sd2048) begin failures++; $display("[TB] FAIL mixed_lane0 actual=%0d required=-2048", dout_im[0]); end
    checks++; if (dout_im[1] !== -24'sd262144) begin failures++; $display("[TB] FAIL mixed_lane1 actual=%0d required=-262144", dout_im[1]); end
    checks++; if (idx_sat !== 1'b0) begin failures++; $display("[TB] FAIL mixed_sat actual=%b required=0", idx_sat); end
  endtask

  task automatic test_sat();
    int ends;
    doReset();
    setAll(12'sd3, -12'sd1, 5'd0);
    din_re[3]   = -12'sd5;
    index_in[3] = 5'd20;
    valid_in    = 1'b1;
    cycle();
    valid_in = 1'b0;
    checks++; if (idx_sat !== 1'b0) begin failures++; $display("[TB] FAIL sat_early actual=%b required=0", idx_sat); end
    cycle();
    checks++; if (idx_sat !== 1'b1) begin failures++; $display("[TB] FAIL sat_rise actual=%b required=1", idx_sat); end
    checks++; if (dout_re[3] !== -24'sd5) begin failures++; $display("[TB] FAIL sat_lane3 actual=%0d required=-5", dout_re[3]); end
    checks++; if (dout_re[0] !== 24'sd12288) begin failures++; $display("[TB] FAIL sat_lane0 actual=%0d required=12288", dout_re[0]); end
    ends = 0;
    setAll(12'sd1, 12'sd1, 5'd4);
    for (int n = 0; n < 66; n++) begin
      valid_in = (n < 64);
      cycle();
      if (frame_end === 1'b1) ends++;
      checks++; if (idx_sat !== 1'b1) begin failures++; $display("[TB] FAIL sat_sticky n=%0d actual=%b required=1", n, idx_sat); end
    end
    checks++; if (ends != 2) begin failures++; $display("[TB] FAIL sat_frames actual=%0d required=2", ends); end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int n = 0; n <= 64; n++) begin
      valid_in = (n < 64);
      if (n < 64) setBeat(n);
      cycle();
      if (n == 0) begin
        checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first actual=%b required=0", valid_out); end
      end else begin
        checks++; if (valid_out !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid out=%0d actual=%b required=1", n - 1, valid_out); end
        checks++; if (frame_start !== ((n - 1) % 32 == 0)) begin failures++; $display("[TB] FAIL b2b_start out=%0d actual=%b required=%b", n - 1, frame_start, ((n - 1) % 32 == 0)); end
        checks++; if (frame_end !== ((n - 1) % 32 == 31)) begin failures++; $display("[TB] FAIL b2b_end out=%0d actual=%b required=%b", n - 1, frame_end, ((n - 1) % 32 == 31)); end
        checks++; if (dout_re[n % 16] !== refShift(patRe(n - 1, n % 16), patIdx(n - 1, n % 16))) begin
          failures++; $display("[TB] FAIL b2b_re out=%0d actual=%0d required=%0d", n - 1, dout_re[n % 16], refShift(patRe(n - 1, n % 16), patIdx(n - 1, n % 16)));
        end
      end
    end
    valid_in = 1'b0;
    cycle();
    checks++; if (valid_out !== 1'b0 || frame_start !== 1'b0 || frame_end !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_drain actual=%b%b%b required=000", valid_out, frame_start, frame_end);
    end
  endtask

  task automatic test_gaps();
    int  sent, outCnt, prevBeat, lastBeat, ends;
    bit  curValid, prevValid;
    doReset();
    sent = 0; outCnt = 0; prevBeat = 0; lastBeat = -1; ends = 0; prevValid = 1'b0;
    for (int it = 0; it < 120; it++) begin
      curValid = (sent < 32) && !((it % 7 == 3) || (it % 5 == 1) || (it >= 20 && it < 26));
      valid_in = curValid;
      if (curValid) setBeat(sent);
      cycle();
      if (prevValid) lastBeat = prevBeat;
      checks++; if (valid_out !== prevValid) begin failures++; $display("[TB] FAIL gap_valid it=%0d actual=%b required=%b", it, valid_out, prevValid); end
      checks++; if (frame_end !== (prevValid && outCnt == 31)) begin failures++; $display("[TB] FAIL gap_end it=%0d actual=%b required=%b", it, frame_end, (prevValid && outCnt == 31)); end
      checks++; if (frame_start !== (prevValid && outCnt == 0)) begin failures++; $display("[TB] FAIL gap_start it=%0d actual=%b required=%b", it, frame_start, (prevValid && outCnt == 0)); end
      if (frame_end === 1'b1) ends++;
      if (prevValid) outCnt++;
      if (lastBeat >= 0) begin
        checks++; if (dout_re[it % 16] !== refShift(patRe(lastBeat, it % 16), patIdx(lastBeat, it % 16))) begin
          failures++; $display("[TB] FAIL gap_re beat=%0d actual=%0d required=%0d", lastBeat, dout_re[it % 16], refShift(patRe(lastBeat, it % 16), patIdx(lastBeat, it % 16)));
        end
        checks++; if (dout_im[(it + 5) % 16] !== refShift(patIm(lastBeat, (it + 5) % 16), patIdx(lastBeat, (it + 5) % 16))) begin
          failures++; $display("[TB] FAIL gap_im beat=%0d actual=%0d required=%0d", lastBeat, dout_im[(it + 5) % 16], refShift(patIm(lastBeat, (it + 5) % 16), patIdx(lastBeat, (it + 5) % 16)));
        end
      end
      prevValid = curValid;
      prevBeat  = sent;
      if (curValid) sent++;
    end
    checks++; if (ends != 1 || outCnt != 32) begin failures++; $display("[TB] FAIL gap_totals actual=%0d/%0d required=1/32", ends, outCnt); end
  endtask

  task automatic test_mid_reset();
    doReset();
    for (int n = 0; n < 10; n++) begin
      setBeat(n);
      valid_in = 1'b1;
      cycle();
    end
    checks++; if (idx_sat !== 1'b1 || valid_out !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre actual=%b%b required=11", idx_sat, valid_out); end
    rst = 1'b1;
    #2;
    checks++; if (valid_out !== 1'b0 || frame_start !== 1'b0 || frame_end !== 1'b0 || idx_sat !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_async actual=%b%b%b%b required=0000", valid_out, frame_start, frame_end, idx_sat);
    end
    checks++; if (dout_re[0] !== 24'sd0 || dout_im[7] !== 24'sd0) begin failures++; $display("[TB] FAIL midrst_dout actual=%0d/%0d required=0/0", dout_re[0], dout_im[7]); end
    valid_in = 1'b0;
    cycle();
    rst = 1'b0;
    for (int n = 0; n <= 33; n++) begin
      valid_in = (n < 32);
      if (n < 32) setBeat(n);
      cycle();
      checks++; if (valid_out !== (n >= 1 && n <= 32)) begin failures++; $display("[TB] FAIL midrst_valid n=%0d actual=%b required=%b", n, valid_out, (n >= 1 && n <= 32)); end
      checks++; if (frame_start !== (n == 1)) begin failures++; $display("[TB] FAIL midrst_start n=%0d actual=%b required=%b", n, frame_start, (n == 1)); end
      checks++; if (frame_end !== (n == 32)) begin failures++; $display("[TB] FAIL midrst_end n=%0d actual=%b required=%b", n, frame_end, (n == 32)); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    setAll(12'sd0, 12'sd0, 5'd0);
    test_reset();
    test_unit_shift();
    test_mixed_index();
    test_sat();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
